// File: rtl/cv32e40p_cnn_tile_engine_if.sv
// rtl/cv32e40p_cnn_tile_engine_if.sv - command, pixel-stream and result bundle for the CNN tile engine
//
// Signal groups:
//   cmd_*   : command handshake (valid/ready), opcode and two 32-bit arguments
//   din_*   : tile pixel stream into the engine, raster order
//   dout_*  : saturated convolution results out of the engine, with raster index
//   result_o: max-pooled scalar
//   done_o / err_o : single-cycle completion / rejection pulses
// Modports: master drives commands and pixels; slave is the engine.
interface cv32e40p_cnn_tile_engine_if #(
  parameter int DATA_W = 16,
  parameter int OUT_W  = 32
);
  logic                     cmd_valid_i;
  logic                     cmd_ready_o;
  logic [2:0]               cmd_op_i;
  logic [31:0]              cmd_arg0_i;
  logic [31:0]              cmd_arg1_i;
  logic                     din_valid_i;
  logic                     din_ready_o;
  logic signed [DATA_W-1:0] din_i;
  logic                     dout_valid_o;
  logic                     dout_ready_i;
  logic signed [OUT_W-1:0]  dout_o;
  logic [5:0]               dout_idx_o;
  logic signed [OUT_W-1:0]  result_o;
  logic                     done_o;
  logic                     err_o;

  modport master (
    output cmd_valid_i, cmd_op_i, cmd_arg0_i, cmd_arg1_i, din_valid_i, din_i, dout_ready_i,
    input  cmd_ready_o, din_ready_o, dout_valid_o, dout_o, dout_idx_o, result_o, done_o, err_o
  );

  modport slave (
    input  cmd_valid_i, cmd_op_i, cmd_arg0_i, cmd_arg1_i, din_valid_i, din_i, dout_ready_i,
    output cmd_ready_o, din_ready_o, dout_valid_o, dout_o, dout_idx_o, result_o, done_o, err_o
  );
endinterface

// File: rtl/cv32e40p_cnn_tile_engine.sv
// rtl/cv32e40p_cnn_tile_engine.sv - 3x3 valid-convolution tile engine with ReLU, streamed results and max-pool
//
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : cv32e40p_cnn_tile_engine_if.slave (command, pixel stream, result stream,
//                pooled scalar, done/err pulses)
// Parameters: DATA_W (weight/pixel width), IN_DIM (tile edge), OUT_W (result width).
// Optional feature: define CNN_MAXPOOL_EN to implement the MAXPOOL command and result_o;
// otherwise opcode 5 is rejected and result_o reads 0.
module cv32e40p_cnn_tile_engine #(
  parameter int DATA_W = 16,
  parameter int IN_DIM = 4,
  parameter int OUT_W  = 32
) (
  input logic                       clk,
  input logic                       rst_n,
  cv32e40p_cnn_tile_engine_if.slave bus
);
  localparam int OUT_DIM = IN_DIM - 2;
  localparam int NOUT    = OUT_DIM * OUT_DIM;
  localparam int NPIX    = IN_DIM * IN_DIM;
  localparam int PROD_W  = 2 * DATA_W;
  localparam int ACC_W   = 2 * DATA_W + 4;
  localparam int PIX_AW  = (NPIX > 1) ? $clog2(NPIX) : 1;
  localparam int ACC_AW  = (NOUT > 1) ? $clog2(NOUT) : 1;
  // Comparison width wide enough to hold both the accumulator and the output range.
  localparam int CW      = ((ACC_W > OUT_W) ? ACC_W : OUT_W) + 1;
  localparam logic signed [CW-1:0] SAT_MAX = {{(CW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [CW-1:0] SAT_MIN = {{(CW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  localparam logic [2:0] OP_LOAD_W    = 3'd1;
  localparam logic [2:0] OP_LOAD_TILE = 3'd2;
  localparam logic [2:0] OP_CONV      = 3'd3;
  localparam logic [2:0] OP_STORE     = 3'd4;
  localparam logic [2:0] OP_MAXPOOL   = 3'd5;
  localparam logic [2:0] OP_CLEAR     = 3'd6;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_CALC, S_STORE} state_t;

  state_t                   state_q, state_d;
  logic [5:0]               cnt_q, cnt_d;     // beat / tap / result index, by state
  logic                     done_q, done_d, err_q, err_d;
  logic                     relu_q;
  logic                     w_we, tile_we, acc_clr, acc_we, relu_we, relu_last;
  logic signed [DATA_W-1:0] w_q    [9];
  logic signed [DATA_W-1:0] tile_q [NPIX];
  logic signed [ACC_W-1:0]  acc_q  [NOUT];
  logic signed [ACC_W-1:0]  acc_tap[NOUT];
  int                       ky, kx;
  logic                     unused_arg1;

  assign unused_arg1 = ^bus.cmd_arg1_i[31:DATA_W];

  // Clamp to the OUT_W range; degenerates to sign extension when OUT_W >= ACC_W.
  function automatic logic signed [OUT_W-1:0] sat(input logic signed [ACC_W-1:0] a);
    logic signed [CW-1:0] x;
    x = CW'(a);
    if (x > SAT_MAX) return SAT_MAX[OUT_W-1:0];
    if (x < SAT_MIN) return SAT_MIN[OUT_W-1:0];
    return x[OUT_W-1:0];
  endfunction

  // One kernel tap per CALC cycle, applied to every output position in parallel.
  always_comb begin
    logic signed [PROD_W-1:0] prod;
    logic [PIX_AW-1:0]        pix;
    ky   = (cnt_q >= 6'd6) ? 2 : (cnt_q >= 6'd3) ? 1 : 0;
    kx   = int'(cnt_q) - 3 * ky;
    prod = '0;
    pix  = '0;
    for (int r = 0; r < OUT_DIM; r++) begin
      for (int c = 0; c < OUT_DIM; c++) begin
        pix  = PIX_AW'((r + ky) * IN_DIM + c + kx);
        prod = tile_q[pix] * w_q[cnt_q[3:0]];
        // Tap 0 starts a fresh sum instead of needing a separate clear cycle.
        acc_tap[r*OUT_DIM+c] = ((cnt_q == 6'd0) ? '0 : acc_q[r*OUT_DIM+c]) + ACC_W'(prod);
      end
    end
  end

  assign relu_last = relu_q && (cnt_q == 6'd8);

`ifdef CNN_MAXPOOL_EN
  logic                    res_we;
  logic signed [OUT_W-1:0] result_q, pool_max;

  // Strict '>' keeps the lowest index on ties.
  always_comb begin
    pool_max = sat(acc_q[0]);
    for (int i = 1; i < NOUT; i++)
      if (sat(acc_q[i]) > pool_max) pool_max = sat(acc_q[i]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       result_q <= '0;
    else if (acc_clr) result_q <= '0;
    else if (res_we)  result_q <= pool_max;
  end

  assign bus.result_o = result_q;
`else
  assign bus.result_o = '0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      relu_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      err_q   <= err_d;
      if (relu_we) relu_q <= bus.cmd_arg0_i[0];
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    w_we    = 1'b0;
    tile_we = 1'b0;
    acc_clr = 1'b0;
    acc_we  = 1'b0;
    relu_we = 1'b0;
`ifdef CNN_MAXPOOL_EN
    res_we  = 1'b0;
`endif
    case (state_q)
      S_IDLE: if (bus.cmd_valid_i) begin
        cnt_d = '0;
        case (bus.cmd_op_i)
          OP_LOAD_W: begin
            if (bus.cmd_arg0_i > 32'd8) err_d = 1'b1;
            else begin w_we = 1'b1; done_d = 1'b1; end
          end
          OP_LOAD_TILE: state_d = S_LOAD;
          OP_CONV:      begin state_d = S_CALC; relu_we = 1'b1; end
          OP_STORE:     state_d = S_STORE;
`ifdef CNN_MAXPOOL_EN
          OP_MAXPOOL:   begin res_we = 1'b1; done_d = 1'b1; end
`endif
          OP_CLEAR:     begin acc_clr = 1'b1; done_d = 1'b1; end
          default:      err_d = 1'b1;
        endcase
      end
      S_LOAD: if (bus.din_valid_i) begin
        tile_we = 1'b1;
        if (cnt_q == 6'(NPIX - 1)) begin state_d = S_IDLE; done_d = 1'b1; end
        else cnt_d = cnt_q + 6'd1;
      end
      S_CALC: begin
        acc_we = 1'b1;
        if (cnt_q == 6'd8) begin state_d = S_IDLE; done_d = 1'b1; end
        else cnt_d = cnt_q + 6'd1;
      end
      S_STORE: if (bus.dout_ready_i) begin
        if (cnt_q == 6'(NOUT - 1)) begin state_d = S_IDLE; done_d = 1'b1; end
        else cnt_d = cnt_q + 6'd1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 9; i++)    w_q[i]    <= '0;
      for (int i = 0; i < NPIX; i++) tile_q[i] <= '0;
      for (int i = 0; i < NOUT; i++) acc_q[i]  <= '0;
    end else begin
      if (w_we)    w_q[bus.cmd_arg0_i[3:0]]   <= bus.cmd_arg1_i[DATA_W-1:0];
      if (tile_we) tile_q[cnt_q[PIX_AW-1:0]] <= bus.din_i;
      for (int i = 0; i < NOUT; i++) begin
        if (acc_clr)     acc_q[i] <= '0;
        else if (acc_we) acc_q[i] <= (relu_last && acc_tap[i][ACC_W-1]) ? '0 : acc_tap[i];
      end
    end
  end

  assign bus.cmd_ready_o  = (state_q == S_IDLE);
  assign bus.din_ready_o  = (state_q == S_LOAD);
  assign bus.dout_valid_o = (state_q == S_STORE);
  assign bus.dout_o       = (state_q == S_STORE) ? sat(acc_q[cnt_q[ACC_AW-1:0]]) : '0;
  assign bus.dout_idx_o   = (state_q == S_STORE) ? cnt_q : 6'd0;
  assign bus.done_o       = done_q;
  assign bus.err_o        = err_q;
endmodule

// File: tb/tb_cv32e40p_cnn_tile_engine.sv
// tb/tb_cv32e40p_cnn_tile_engine.sv - directed self-checking bench for the CNN tile engine (OUT_W 32 and 16)
module tb_cv32e40p_cnn_tile_engine;
  logic clk, rst_n;
  logic cmd_valid, din_valid, dout_ready;
  logic [2:0] cmd_op;
  logic [31:0] cmd_arg0, cmd_arg1;
  logic signed [15:0] din;
  logic signed [15:0] pix [16];
  logic signed [31:0] exp32 [4];
  logic signed [15:0] exp16 [4];
  int nvec = 0;
  int nerr = 0;

  cv32e40p_cnn_tile_engine_if #(.DATA_W(16), .OUT_W(32)) b32();
  cv32e40p_cnn_tile_engine_if #(.DATA_W(16), .OUT_W(16)) b16();

  cv32e40p_cnn_tile_engine #(.DATA_W(16), .IN_DIM(4), .OUT_W(32)) dut32 (.clk(clk), .rst_n(rst_n), .bus(b32));
  cv32e40p_cnn_tile_engine #(.DATA_W(16), .IN_DIM(4), .OUT_W(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(b16));

  assign b32.cmd_valid_i = cmd_valid;   assign b16.cmd_valid_i = cmd_valid;
  assign b32.cmd_op_i = cmd_op;         assign b16.cmd_op_i = cmd_op;
  assign b32.cmd_arg0_i = cmd_arg0;     assign b16.cmd_arg0_i = cmd_arg0;
  assign b32.cmd_arg1_i = cmd_arg1;     assign b16.cmd_arg1_i = cmd_arg1;
  assign b32.din_valid_i = din_valid;   assign b16.din_valid_i = din_valid;
  assign b32.din_i = din;               assign b16.din_i = din;
  assign b32.dout_ready_i = dout_ready; assign b16.dout_ready_i = dout_ready;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] expv);
    nvec++;
    assert (obs === expv) else begin
      nerr++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, expv);
    end
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a0, input logic [31:0] a1);
    cmd_valid = 1'b1; cmd_op = op; cmd_arg0 = a0; cmd_arg1 = a1;
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic load_w(input int idx, input logic [31:0] val);
    issue(3'd1, idx, val);
    chk("ldw_done", b32.done_o, 1);
  endtask

  task automatic load_all_w(input logic [31:0] val);
    for (int k = 0; k < 9; k++) load_w(k, val);
  endtask

  task automatic load_tile();
    issue(3'd2, 0, 0);
    chk("ld_din_ready", b32.din_ready_o, 1);
    for (int i = 0; i < 16; i++) begin
      if (i == 5) begin din_valid = 1'b0; step(); step(); end
      din_valid = 1'b1; din = pix[i];
      step();
    end
    din_valid = 1'b0;
    chk("ld_done", b32.done_o, 1);
  endtask

  task automatic conv(input logic relu);
    int n;
    issue(3'd3, {31'd0, relu}, 0);
    n = 1;
    while (b32.done_o !== 1'b1 && n < 40) begin step(); n++; end
    chk("conv_latency", n, 10);
    chk("conv_ready", b32.cmd_ready_o, 1);
  endtask

  task automatic set_exp(input int a, input int b, input int c, input int d);
    exp32[0] = a; exp32[1] = b; exp32[2] = c; exp32[3] = d;
    for (int i = 0; i < 4; i++) exp16[i] = exp32[i][15:0];
  endtask

  task automatic store(input logic stall);
    issue(3'd4, 0, 0);
    for (int i = 0; i < 4; i++) begin
      chk("st_valid", b32.dout_valid_o, 1);
      chk("st_idx", b32.dout_idx_o, i);
      chk("st_dout32", b32.dout_o, exp32[i]);
      chk("st_dout16", b16.dout_o, exp16[i]);
      if (i == 0 && stall) begin
        dout_ready = 1'b0;
        repeat (5) begin
          step();
          chk("stall_idx", b32.dout_idx_o, 0);
          chk("stall_dout", b32.dout_o, exp32[0]);
        end
        dout_ready = 1'b1;
      end
      step();
    end
    chk("st_done", b32.done_o, 1);
    chk("st_valid_end", b32.dout_valid_o, 0);
  endtask

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_arg0 = '0; cmd_arg1 = '0;
    din_valid = 1'b0; din = '0; dout_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", b32.cmd_ready_o, 1);
    chk("rst_done", b32.done_o, 0);
    chk("rst_err", b32.err_o, 0);
    chk("rst_dout_valid", b32.dout_valid_o, 0);
    chk("rst_din_ready", b32.din_ready_o, 0);
    chk("rst_result", b32.result_o, 0);
    rst_n = 1'b1;
    step();

    // Weights 1..9, tile 1..16
    for (int k = 0; k < 9; k++) load_w(k, k + 1);
    issue(3'd1, 9, 100);
    chk("ldw9_err", b32.err_o, 1);
    chk("ldw9_nodone", b32.done_o, 0);
    issue(3'd7, 0, 0);
    chk("op7_err", b32.err_o, 1);
    issue(3'd0, 0, 0);
    chk("op0_err", b32.err_o, 1);
    chk("op0_nodone", b32.done_o, 0);
    for (int i = 0; i < 16; i++) pix[i] = 16'(i + 1);
    load_tile();
    conv(1'b0);
    set_exp(348, 393, 528, 573);
    store(1'b0);

    issue(3'd5, 0, 0);
`ifdef CNN_MAXPOOL_EN
    chk("mp_done", b32.done_o, 1);
    chk("mp_err", b32.err_o, 0);
    chk("mp_result32", b32.result_o, 573);
    chk("mp_result16", b16.result_o, 573);
`else
    chk("mp_err", b32.err_o, 1);
    chk("mp_nodone", b32.done_o, 0);
    chk("mp_result", b32.result_o, 0);
`endif
    store(1'b1);

    issue(3'd6, 0, 0);
    chk("clr_done", b32.done_o, 1);
    chk("clr_result", b32.result_o, 0);
    set_exp(0, 0, 0, 0);
    store(1'b0);

    // Weights -1: ReLU clamps every output, plain conv gives negated window sums
    load_all_w(32'hFFFF_FFFF);
    conv(1'b1);
    set_exp(0, 0, 0, 0);
    store(1'b0);
    conv(1'b0);
    set_exp(-54, -63, -90, -99);
    store(1'b0);

    // Saturation at both output widths
    for (int i = 0; i < 16; i++) pix[i] = 16'sd32767;
    load_tile();
    load_all_w(32'd32767);
    conv(1'b0);
    for (int i = 0; i < 4; i++) begin exp32[i] = 32'sd2147483647; exp16[i] = 16'sd32767; end
    store(1'b0);
    load_all_w(32'hFFFF_8000);
    conv(1'b0);
    for (int i = 0; i < 4; i++) begin exp32[i] = -32'sd2147483647 - 32'sd1; exp16[i] = -16'sd32767 - 16'sd1; end
    store(1'b0);

    // Reset at tap 4 of CALC
    issue(3'd3, 0, 0);
    repeat (4) step();
    rst_n = 1'b0;
    #1;
    chk("midrst_ready", b32.cmd_ready_o, 1);
    chk("midrst_done", b32.done_o, 0);
    step();
    rst_n = 1'b1;
    repeat (12) begin
      step();
      chk("midrst_no_done", b32.done_o, 0);
    end
    chk("midrst_result", b32.result_o, 0);
    set_exp(0, 0, 0, 0);
    store(1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/cv32e40p_cnn_tile_engine.md
# cv32e40p_cnn_tile_engine

Parametrised convolution tile engine for the CV32E40P execution stage, sitting beside the ALU/MULT units and driven by the custom CNN opcodes. It holds a 3x3 signed kernel and an IN_DIM x IN_DIM input tile. It computes the (IN_DIM-2)^2 valid-convolution outputs on a sequential multi-cycle datapath, with optional ReLU. It streams results back through a valid/ready port and can reduce them to a single max-pooled scalar.

## Interface
- DATA_W, 16: signed width of weights and tile pixels (8..16).
- IN_DIM, 4: input tile edge (3..8); OUT_DIM = IN_DIM-2; NOUT = OUT_DIM^2.
- OUT_W, 32: signed width of stored/pooled results (16..32).
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- cmd_valid_i  in  1  command present.
- cmd_ready_o  out  1  engine accepts command (high only in IDLE).
- cmd_op_i  in  3  1 LOAD_W, 2 LOAD_TILE, 3 CONV, 4 STORE, 5 MAXPOOL, 6 CLEAR; 0/7 illegal.
- cmd_arg0_i  in  32  LOAD_W: kernel index 0..8; CONV: bit0 = ReLU enable.
- cmd_arg1_i  in  32  LOAD_W: weight value (low DATA_W bits).
- din_valid_i / din_ready_o  in/out  1  tile pixel handshake.
- din_i  in  DATA_W  pixel, raster order.
- dout_valid_o / dout_ready_i  out/in  1  result handshake.
- dout_o  out  OUT_W  saturated result; dout_idx_o  out  6  raster index of dout_o.
- result_o  out  OUT_W  MAXPOOL scalar, held until next MAXPOOL/CLEAR/reset.
- done_o  out  1  one-cycle pulse on command completion.
- err_o  out  1  one-cycle pulse on rejected command.

## Operation
- Handshake: a command is accepted on the clk edge with cmd_valid_i && cmd_ready_o. Only one command is outstanding at a time.
- FSM states: IDLE, LOAD, CALC, STORE.
- IDLE: cmd_ready_o=1.
  - LOAD_W: writes w[arg0] and pulses done_o next cycle. Index > 8 gives err_o instead and no write.
  - CLEAR: zeroes the accumulators and result_o, then done_o.
  - Illegal opcode: err_o, no state change.
- LOAD: din_ready_o=1. Beat counter runs 0..IN_DIM^2-1 and stores tile[cnt]. After the last beat: IDLE and done_o. Other inputs are ignored.
- CALC:
  - Tap counter k runs 0..8 (ky=k/3, kx=k%3). The first tap clears the accumulators.
  - Every cycle, all NOUT accumulators update in parallel: acc[r][c] += tile[r+ky][c+kx]*w[k].
  - After tap 8, if the latched ReLU bit is set, negative accumulators are forced to 0. Then IDLE and done_o.
- STORE:
  - dout_valid_o=1 with dout_o=sat(acc[idx]) and idx 0..NOUT-1.
  - idx advances on dout_valid_o && dout_ready_i.
  - The final transfer returns the FSM to IDLE and pulses done_o.
  - dout_o and dout_idx_o stay stable while dout_ready_i is low.
- MAXPOOL: signed maximum over sat(acc[0..NOUT-1]) is written to result_o, then done_o. Ties keep the lowest index.
- Arithmetic:
  - Products are 2*DATA_W bits signed; ACC_W = 2*DATA_W+4, so 9 products cannot overflow.
  - sat() clamps to [-2^(OUT_W-1), 2^(OUT_W-1)-1]. When OUT_W >= ACC_W, sat() is a plain sign-extension.
- Reset values:
  - All outputs 0, except cmd_ready_o=1.
  - Weights, tile, accumulators and counters are 0; FSM is IDLE.
  - Reset mid-operation aborts the command with no done_o.

## Timing
- LOAD_W, CLEAR, MAXPOOL: done_o in cycle 1 after the accept edge. cmd_ready_o stays high, so back-to-back commands are accepted every cycle.
- CONV: 9 CALC cycles after accept; done_o and cmd_ready_o are both high in cycle 10.
- LOAD_TILE: IN_DIM^2 beats minimum; din_ready_o is high from cycle 1. done_o comes the cycle after the final beat.
- STORE: dout_valid_o is high from cycle 1. At best, NOUT cycles plus 1 for done_o.
- din_valid_i stalls extend LOAD and dout_ready_i stalls extend STORE without limit. There is no timeout.
- done_o and err_o never assert in the same cycle.

## Configuration
- CNN_MAXPOOL_EN defined: MAXPOOL and result_o are implemented as above.
- CNN_MAXPOOL_EN undefined:
  - Opcode 5 is illegal and pulses err_o.
  - result_o is tied to 0 and the comparator tree is removed.

## Test plan
- IN_DIM=4, DATA_W=16, OUT_W=32.
  - LOAD_W w[0..8]=1..9, LOAD_TILE pixels 1..16, CONV (arg0=0), STORE with dout_ready_i=1 -> dout_o 348, 393, 528, 573 at idx 0..3.
  - done_o at cycle 10 after CONV accept.
- Same tile, weights all -1, CONV with arg0=1 -> all four outputs 0. With arg0=0 -> idx0 = -54.
- OUT_W=16: tile all 32767, weights all 32767 -> dout_o = 32767. Weights all -32768 -> dout_o = -32768.
- After the first scenario, MAXPOOL -> result_o = 573 with done_o one cycle later. Built without CNN_MAXPOOL_EN -> err_o pulse and result_o = 0.
- Stall and illegal-input cases:
  - During STORE, hold dout_ready_i low for 5 cycles -> dout_o/dout_idx_o stable.
  - LOAD_W index 9 -> err_o, weights unchanged.
  - Opcode 7 -> err_o.
- Assert rst_n low mid-CALC (tap 4) -> cmd_ready_o=1, no done_o. A following STORE -> all outputs 0.
